// File: rtl/unidade_controle_mc.sv
// Multicycle MIPS main control FSM: opcode decode, datapath enables/mux selects,
// ULAOp generation and parameterised memory wait states. Moore outputs decode state_q.
module unidade_controle_mc #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ULAOp,
  output logic       illegal_op,
  output logic [3:0] state_out
);

  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  typedef enum logic [3:0] {
    S_RESET         = 4'd0,
    S_FETCH         = 4'd1,
    S_FETCH_WAIT    = 4'd2,
    S_IR_LOAD       = 4'd3,
    S_DECODE        = 4'd4,
    S_MEM_ADDR      = 4'd5,
    S_MEM_READ      = 4'd6,
    S_MEM_READ_WAIT = 4'd7,
    S_MEM_WB        = 4'd8,
    S_MEM_WRITE     = 4'd9,
    S_R_EXEC        = 4'd10,
    S_R_WB          = 4'd11,
    S_BRANCH        = 4'd12,
    S_JUMP          = 4'd13,
    S_ILLEGAL       = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the wait counter is loaded on the read-issue state and counts down to 1.
  always_comb begin
    state_d = S_RESET;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        cnt_d   = CW'(MEM_WAIT);
        state_d = (MEM_WAIT > 0) ? S_FETCH_WAIT : S_IR_LOAD;
      end
      S_FETCH_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = S_IR_LOAD;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = S_FETCH_WAIT;
        end
      end
      S_IR_LOAD: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        cnt_d   = CW'(MEM_WAIT);
        state_d = (MEM_WAIT > 0) ? S_MEM_READ_WAIT : S_MEM_WB;
      end
      S_MEM_READ_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = S_MEM_WB;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = S_MEM_READ_WAIT;
        end
      end
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ILLEGAL:   state_d = S_FETCH;
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore output decode; anything not named for a state stays 0.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ULAOp       = 2'b00;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH, S_FETCH_WAIT: MemRead = 1'b1;
      S_IR_LOAD: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ, S_MEM_READ_WAIT: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ULAOp   = 2'b10;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ULAOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ILLEGAL: illegal_op = 1'b1;
      default: PCWrite = 1'b0;
    endcase
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Scoreboard bench: three controllers (MEM_WAIT = 0, 1, 3) share clock/reset/opcode;
// expected per-cycle {state, outputs} are queued per instance and popped each cycle.
module tb_unidade_controle_mc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;

  logic [2:0] pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, ill;
  logic [1:0] asb [3];
  logic [1:0] pcs [3];
  logic [1:0] ulo [3];
  logic [3:0] st  [3];

  int checks = 0;
  int failures = 0;

  logic [20:0] q0 [$];
  logic [20:0] q1 [$];
  logic [20:0] q2 [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    unidade_controle_mc #(.MEM_WAIT((g == 0) ? 0 : (g == 1) ? 1 : 3)) dut (
      .clk(clk), .reset(reset), .opcode(opcode),
      .PCWrite(pcw[g]), .PCWriteCond(pcwc[g]), .IorD(iord[g]), .MemRead(mrd[g]),
      .MemWrite(mwr[g]), .IRWrite(irw[g]), .RegDst(rdst[g]), .MemtoReg(m2r[g]),
      .RegWrite(rw[g]), .ALUSrcA(asa[g]), .ALUSrcB(asb[g]), .PCSource(pcs[g]),
      .ULAOp(ulo[g]), .illegal_op(ill[g]), .state_out(st[g])
    );
  end

  function automatic logic [20:0] obs(input int d);
    return {st[d], pcw[d], pcwc[d], iord[d], mrd[d], mwr[d], irw[d], rdst[d], m2r[d],
            rw[d], asa[d], asb[d], pcs[d], ulo[d], ill[d]};
  endfunction

  // Expected outputs per state, straight from the state/output table.
  function automatic logic [20:0] model(input logic [3:0] s);
    logic pw, pwc, iod, mr, mw, ir, rd, mtr, rgw, sa, il;
    logic [1:0] sb, ps, uo;
    {pw, pwc, iod, mr, mw, ir, rd, mtr, rgw, sa, il} = 11'd0;
    sb = 2'b00; ps = 2'b00; uo = 2'b00;
    case (s)
      4'd1, 4'd2:  mr = 1'b1;
      4'd3:        begin ir = 1'b1; pw = 1'b1; sb = 2'b01; end
      4'd4:        sb = 2'b11;
      4'd5:        begin sa = 1'b1; sb = 2'b10; end
      4'd6, 4'd7:  begin mr = 1'b1; iod = 1'b1; end
      4'd8:        begin rgw = 1'b1; mtr = 1'b1; end
      4'd9:        begin mw = 1'b1; iod = 1'b1; end
      4'd10:       begin sa = 1'b1; uo = 2'b10; end
      4'd11:       begin rgw = 1'b1; rd = 1'b1; end
      4'd12:       begin sa = 1'b1; uo = 2'b01; pwc = 1'b1; ps = 2'b01; end
      4'd13:       begin pw = 1'b1; ps = 2'b10; end
      4'd14:       il = 1'b1;
      default:     il = 1'b0;
    endcase
    return {s, pw, pwc, iod, mr, mw, ir, rd, mtr, rgw, sa, sb, ps, uo, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input int d, input logic [3:0] s);
    case (d)
      0:       q0.push_back(model(s));
      1:       q1.push_back(model(s));
      default: q2.push_back(model(s));
    endcase
  endtask

  task automatic push_instr(input int d, input logic [5:0] op);
    int mw;
    mw = (d == 0) ? 0 : (d == 1) ? 1 : 3;
    push(d, 4'd1);
    repeat (mw) push(d, 4'd2);
    push(d, 4'd3);
    push(d, 4'd4);
    case (op)
      6'b000000: begin push(d, 4'd10); push(d, 4'd11); end
      6'b100011: begin
        push(d, 4'd5); push(d, 4'd6);
        repeat (mw) push(d, 4'd7);
        push(d, 4'd8);
      end
      6'b101011: begin push(d, 4'd5); push(d, 4'd9); end
      6'b000100: push(d, 4'd12);
      6'b000010: push(d, 4'd13);
      default:   push(d, 4'd14);
    endcase
  endtask

  // Reset everything, hold opcode, queue n instructions per instance, then compare cycle by cycle.
  task automatic run_prog(input string tag, input logic [5:0] op, input int n);
    logic [20:0] e;
    reset = 1'b1;
    opcode = op;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk({tag, "_rst"}, 32'(obs(d)), 32'(model(4'd0)));
    for (int d = 0; d < 3; d++) for (int k = 0; k < n; k++) push_instr(d, op);
    reset = 1'b0;
    for (int cyc = 0; cyc < 200 && (q0.size() + q1.size() + q2.size()) > 0; cyc++) begin
      @(posedge clk); #1;
      if (q0.size() > 0) begin e = q0.pop_front(); chk({tag, "_w0"}, 32'(obs(0)), 32'(e)); end
      if (q1.size() > 0) begin e = q1.pop_front(); chk({tag, "_w1"}, 32'(obs(1)), 32'(e)); end
      if (q2.size() > 0) begin e = q2.pop_front(); chk({tag, "_w3"}, 32'(obs(2)), 32'(e)); end
      for (int d = 0; d < 3; d++) begin
        chk({tag, "_rdwr"}, 32'(mrd[d] & mwr[d]), 32'd0);
        chk({tag, "_pcw"}, 32'(pcw[d] & pcwc[d]), 32'd0);
      end
    end
    chk({tag, "_drain"}, 32'(q0.size() + q1.size() + q2.size()), 32'd0);
  endtask

  initial begin
    int found;
    repeat (2) @(negedge clk);

    run_prog("rtype", 6'b000000, 2);
    run_prog("lw", 6'b100011, 2);
    run_prog("sw", 6'b101011, 2);
    run_prog("beq", 6'b000100, 2);
    run_prog("j", 6'b000010, 2);
    run_prog("ill", 6'b111111, 2);

    // Reset asserted mid-cycle while running: outputs collapse without a clock edge.
    opcode = 6'b000000;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) chk("midrst", 32'(obs(d)), 32'(model(4'd0)));

    // Reset during MEM_WRITE drops MemWrite in the same cycle.
    opcode = 6'b101011;
    @(negedge clk); reset = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 30 && found == 0; cyc++) begin
      @(posedge clk); #1;
      if (st[1] == 4'd9) found = 1;
    end
    chk("sw_reach", 32'(found), 32'd1);
    chk("sw_mwr_on", 32'(mwr[1]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("sw_mwr_off", 32'(mwr[1]), 32'd0);
    chk("sw_state_rst", 32'(st[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unidade_controle_mc.md
Name: unidade_controle_mc

Overview:
- Multicycle MIPS main control FSM.
- Decodes the instruction opcode and drives all datapath enables and mux selects.
- Produces the 2-bit ULAOp that feeds the ALU-control stage directly downstream.
- Inserts parameterised wait states for the synchronous instruction/data memory.

Parameters:
- MEM_WAIT, 1, extra cycles between issuing a memory read and the read data being valid (0..7). Wait counter width is $clog2(MEM_WAIT+1), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state RESET.
- opcode  in  6  IR[31:26]; IR is stable from DECODE onward.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified externally by ALU zero.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read.
- MemWrite  out  1  memory write.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write register: 0=rt, 1=rd.
- MemtoReg  out  1  write data: 0=ALUOut, 1=MDR.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0=PC, 1=A.
- ALUSrcB  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- ULAOp  out  2  00=add, 01=subtract, 10=decode by funct.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_out  out  4  current state encoding, for debug.

Behaviour:
- Moore FSM; every output is a pure function of the state register. Any output not listed for a state is 0.
- MDR captures memory data every cycle (external). A/B load every cycle (external).
- State encodings: RESET=0, FETCH=1, FETCH_WAIT=2, IR_LOAD=3, DECODE=4, MEM_ADDR=5, MEM_READ=6, MEM_READ_WAIT=7, MEM_WB=8, MEM_WRITE=9, R_EXEC=10, R_WB=11, BRANCH=12, JUMP=13, ILLEGAL=14.
- Reset:
  - Asynchronous reset sets state to RESET and the wait counter to 0. All outputs are 0 and state_out=0.
  - Reset asserted mid-instruction aborts the instruction immediately. No partial write completes after reset asserts.
  - The first edge after reset deasserts moves the FSM to FETCH.
- State outputs and transitions:
  - RESET: all outputs 0 -> FETCH.
  - FETCH: MemRead=1, IorD=0. Loads the wait counter with MEM_WAIT. Goes to FETCH_WAIT if MEM_WAIT>0, else IR_LOAD.
  - FETCH_WAIT: MemRead=1, IorD=0. Counter decrements each cycle. Goes to IR_LOAD in the cycle the counter reaches 1. Occupies exactly MEM_WAIT cycles.
  - IR_LOAD: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ULAOp=00, PCSource=00 (PC<=PC+4) -> DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ULAOp=00 (branch target into ALUOut). Next state by opcode:
    - 000000 -> R_EXEC
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - any other opcode -> ILLEGAL
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ULAOp=00. opcode 100011 -> MEM_READ; otherwise -> MEM_WRITE.
  - MEM_READ: MemRead=1, IorD=1. Loads the counter. Goes to MEM_READ_WAIT if MEM_WAIT>0, else MEM_WB.
  - MEM_READ_WAIT: MemRead=1, IorD=1. Lasts MEM_WAIT cycles, same counter rule as FETCH_WAIT -> MEM_WB.
  - MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
  - MEM_WRITE: MemWrite=1, IorD=1 -> FETCH.
  - R_EXEC: ALUSrcA=1, ALUSrcB=00, ULAOp=10 -> R_WB.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ULAOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
  - JUMP: PCWrite=1, PCSource=10 -> FETCH.
  - ILLEGAL: illegal_op=1 -> FETCH. No register or memory write; PC is already advanced by 4.
- Encodings 15 and any unreachable state go to RESET on the next edge with all outputs 0.
- Invariants:
  - MemRead and MemWrite are never both 1.
  - PCWrite and PCWriteCond are never both 1.
- opcode is ignored in every state except DECODE and MEM_ADDR.

Test Plan:
- Reset, MEM_WAIT=1: assert reset mid-cycle -> all outputs 0 and state_out=0 immediately. After release: FETCH(1), FETCH_WAIT(2), IR_LOAD(3) with IRWrite=PCWrite=1 for exactly 1 cycle.
- R-type (opcode 000000), MEM_WAIT=1: sequence 1,2,3,4,10,11,1. ULAOp=10 only in R_EXEC. RegWrite=1 with RegDst=1 in R_WB only. 6 cycles per instruction.
- lw (100011), MEM_WAIT=1: sequence 1,2,3,4,5,6,7,8. IorD=1 with MemRead=1 in states 6–7. RegWrite=1 with MemtoReg=1 in state 8. 8 cycles per instruction.
- lw with MEM_WAIT=0: sequence 1,3,4,5,6,8. lw with MEM_WAIT=3: FETCH_WAIT and MEM_READ_WAIT each last exactly 3 cycles.
- sw (101011), beq (000100), j (000010), MEM_WAIT=1:
  - sw asserts MemWrite=1 in one cycle of state 9.
  - beq asserts ULAOp=01 with PCWriteCond=1 and PCSource=01 in state 12.
  - j asserts PCWrite=1 with PCSource=10 in state 13.
  - Each returns to FETCH.
- Illegal opcode 111111 in DECODE: state 14, illegal_op=1 for 1 cycle, RegWrite and MemWrite stay 0, next state 1. Assert reset during MEM_WRITE -> MemWrite drops to 0 the same cycle.
